countdown_timer: RTL and testbench
==================================

# countdown_timer

Loadable minutes:seconds countdown timer, the down-counting counterpart to `stopwatch_top`. It uses the same start/stop/reset pulse controls and the same minutes/seconds/status output format. It sits beside the stopwatch in the timekeeping subsystem. It counts a preset value down to 00:00, flags expiry with a one-cycle `done` pulse, and drives the same display path.

## Interface
- `CLKS_PER_SEC`, default 1: clock cycles per one-second tick; must be ≥1. Benches use 1 or 4.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  **asynchronous, active-low reset.** Fixed.
- `start`  in  1  level, sampled each edge: run or resume.
- `stop`  in  1  level: pause.
- `reset`  in  1  synchronous soft reset: return to the preset value and IDLE.
- `load`  in  1  capture `load_min`/`load_sec` as the new preset.
- `load_min`  in  8  preset minutes, 0–255.
- `load_sec`  in  6  preset seconds; values above 59 are clamped to 59.
- `minutes`  out  8  current minutes, registered.
- `seconds`  out  6  current seconds, 0–59, registered.
- `status`  out  2  00 IDLE, 01 RUNNING, 10 PAUSED, 11 EXPIRED.
- `done`  out  1  one-cycle pulse on reaching 00:00.

## Operation
- **`rst_n` low:** preset, `minutes`, `seconds` and prescaler are all 0; `status`=IDLE; `done`=0. Outputs change immediately, without waiting for a clock edge.
- **Control priority per edge:** `reset` > `load` > `stop` > `start`. Only the highest active input acts.
- **`reset`:** counter = preset, prescaler = 0, state goes to IDLE. Applies from any state, including mid-run.
- **`load`:**
  - Preset = {`load_min`, clamp(`load_sec`)}.
  - Counter = the same value, prescaler = 0, state goes to IDLE.
  - `load` is honoured in every state, including RUNNING.
- **States and transitions:**
  - IDLE --`start` and counter≠00:00--> RUNNING, with prescaler = 0.
  - `start` with counter = 00:00 is ignored; the timer stays in IDLE.
  - RUNNING --`stop`--> PAUSED. Counter and prescaler are held.
  - PAUSED --`start`--> RUNNING. The prescaler resumes from its held value and is not cleared.
  - EXPIRED: `start` and `stop` are ignored; only `reset` or `load` leave this state.
- **Tick:** in RUNNING, the prescaler counts 0..`CLKS_PER_SEC`−1. A tick occurs at the edge where the prescaler equals `CLKS_PER_SEC`−1; the prescaler then wraps to 0.
- **Decrement on tick:**
  - If `seconds`>0: `seconds`−1.
  - Otherwise: `seconds`=59 and `minutes`−1.
  - No other wrap exists; 00:00 is never decremented.
- **Expiry:** the tick that produces 00:00 moves the state to EXPIRED and sets `done`=1 in the same edge. `done` is 0 on the following edge.
- **`stop` on the expiry edge:** expiry wins, because `stop` only matters in RUNNING for the next tick. The pause is not applied, and the state is EXPIRED.

## Timing
- **Start latency:** `start` sampled at edge k gives `status`=01 after edge k. The first decrement is visible after edge k+`CLKS_PER_SEC`.
- **Control latency:** `stop`, `reset` and `load` take effect at the sampling edge; outputs update after that edge.
- **Decrement period:** with `start` held high continuously, one decrement every `CLKS_PER_SEC` cycles.
- **`done`:** asserted exactly one cycle per expiry; never asserted by `reset` or `load`.
- **Outputs:** all outputs come from registers; none has a combinational path from the inputs.

## Configuration
- **`COUNTDOWN_AUTO_RELOAD_EN` defined:**
  - On expiry, `done` pulses, the counter reloads the preset, and the state stays RUNNING. EXPIRED is never entered.
  - A preset of 00:00 cannot be started, so no zero-period loop can occur.
- **Not defined:** the timer stops in EXPIRED as described in Operation.

## Test plan
- **Reset:** `rst_n` low mid-RUNNING → `minutes`=0, `seconds`=0, `status`=00, `done`=0, with no clock edge needed.
- **Basic countdown:** `CLKS_PER_SEC`=1, load 1:02, start.
  - Values follow 1:01, 1:00, 0:59 … 0:00 on successive edges.
  - `done` is high for exactly one cycle when 0:00 appears; `status`=11 thereafter.
- **Pause and resume:** `CLKS_PER_SEC`=4, load 0:10, start.
  - Stop 6 cycles later → value 0:09, `status`=10, held for 10 cycles.
  - On restart, the next decrement comes 2 cycles later, because the prescaler continues rather than restarting.
- **Clamp and zero-start:**
  - Load 0:63 → `seconds`=59.
  - Load 0:00, then start → `status` stays 00.
- **Priority:** assert `reset`, `load` and `start` together during RUNNING at 0:05 with preset 0:30, `load_min`=2, `load_sec`=0 → `reset` wins: value 0:30, `status`=00, `done`=0.
- **Auto-reload:** with `COUNTDOWN_AUTO_RELOAD_EN` defined, load 0:02 and start → `done` pulses every 3 ticks, the value cycles 0:01, 0:00, 0:02 …, and `status` stays 01.

Source files
------------

// File: rtl/countdown_timer.sv
// countdown_timer
//   Loadable minutes:seconds countdown timer. Counts a preset value down to
//   00:00, pulses `done` for one cycle on expiry and parks in EXPIRED.
//
//   Optional feature (compile-time macro COUNTDOWN_AUTO_RELOAD_EN):
//     when defined, expiry pulses `done` and the next tick reloads the preset
//     while the timer stays RUNNING. EXPIRED is never entered.
//
//   Parameters
//     CLKS_PER_SEC : clock cycles per one-second tick (>= 1)
//   Ports
//     clk       in   system clock, rising edge
//     rst_n     in   asynchronous active-low reset
//     start     in   run / resume (level)
//     stop      in   pause (level)
//     reset     in   synchronous soft reset to preset, IDLE
//     load      in   capture load_min/load_sec as the new preset
//     load_min  in   [7:0] preset minutes
//     load_sec  in   [5:0] preset seconds, clamped to 59
//     minutes   out  [7:0] current minutes (registered)
//     seconds   out  [5:0] current seconds (registered)
//     status    out  [1:0] 00 IDLE, 01 RUNNING, 10 PAUSED, 11 EXPIRED
//     done      out  one-cycle expiry pulse (registered)
module countdown_timer #(
    parameter int CLKS_PER_SEC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic [5:0] load_sec,
    output logic [7:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] status,
    output logic       done
);

    // Prescaler needs at least one bit even when CLKS_PER_SEC is 1.
    localparam int PW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10,
        EXPIRED = 2'b11
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] psc, psc_nxt;
    logic [7:0]    preset_min, preset_min_nxt, min_nxt;
    logic [5:0]    preset_sec, preset_sec_nxt, sec_nxt;
    logic          done_nxt;

    logic [5:0]    sec_clamped;
    logic [7:0]    dec_min;
    logic [5:0]    dec_sec;
    logic          is_zero, dec_zero, tick;

    always_comb begin
        sec_clamped = (load_sec > 6'd59) ? 6'd59 : load_sec;
        is_zero     = (minutes == 8'd0) && (seconds == 6'd0);
        tick        = (psc == PW'(CLKS_PER_SEC - 1));
        // Decremented value; only meaningful when the counter is non-zero.
        if (seconds != 6'd0) begin
            dec_min = minutes;
            dec_sec = seconds - 6'd1;
        end else begin
            dec_min = minutes - 8'd1;
            dec_sec = 6'd59;
        end
        dec_zero = (dec_min == 8'd0) && (dec_sec == 6'd0);
    end

    always_comb begin
        state_nxt      = state;
        psc_nxt        = psc;
        preset_min_nxt = preset_min;
        preset_sec_nxt = preset_sec;
        min_nxt        = minutes;
        sec_nxt        = seconds;
        done_nxt       = 1'b0;

        if (reset) begin
            min_nxt   = preset_min;
            sec_nxt   = preset_sec;
            psc_nxt   = '0;
            state_nxt = IDLE;
        end else if (load) begin
            preset_min_nxt = load_min;
            preset_sec_nxt = sec_clamped;
            min_nxt        = load_min;
            sec_nxt        = sec_clamped;
            psc_nxt        = '0;
            state_nxt      = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    // A zero counter cannot be started.
                    if (start && !is_zero) begin
                        state_nxt = RUNNING;
                        psc_nxt   = '0;
                    end
                end
                RUNNING: begin
                    if (tick && !is_zero && dec_zero) begin
                        // Expiry beats a simultaneous stop.
                        min_nxt  = dec_min;
                        sec_nxt  = dec_sec;
                        psc_nxt  = '0;
                        done_nxt = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        state_nxt = RUNNING;
`else
                        state_nxt = EXPIRED;
`endif
                    end else if (stop) begin
                        state_nxt = PAUSED;
                    end else if (tick) begin
                        psc_nxt = '0;
                        if (is_zero) begin
                            // Only reachable with auto-reload: 00:00 was
                            // shown for one period, now restart the preset.
                            min_nxt = preset_min;
                            sec_nxt = preset_sec;
                        end else begin
                            min_nxt = dec_min;
                            sec_nxt = dec_sec;
                        end
                    end else begin
                        psc_nxt = psc + PW'(1);
                    end
                end
                PAUSED: begin
                    // Prescaler keeps its value so the second is not restarted.
                    if (!stop && start) state_nxt = RUNNING;
                end
                default: ;  // EXPIRED: only reset/load leave
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            psc        <= '0;
            preset_min <= '0;
            preset_sec <= '0;
            minutes    <= '0;
            seconds    <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            psc        <= psc_nxt;
            preset_min <= preset_min_nxt;
            preset_sec <= preset_sec_nxt;
            minutes    <= min_nxt;
            seconds    <= sec_nxt;
            done       <= done_nxt;
        end
    end

    assign status = state;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: one instance with CLKS_PER_SEC=1 (table vectors,
// full countdown, priority) and one with CLKS_PER_SEC=4 (pause/resume).
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, stop = 1'b0, reset = 1'b0, load = 1'b0;
    logic [7:0] load_min = 8'd0;
    logic [5:0] load_sec = 6'd0;

    logic [7:0] min_a, min_b;
    logic [5:0] sec_a, sec_b;
    logic [1:0] st_a, st_b;
    logic       done_a, done_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    countdown_timer #(.CLKS_PER_SEC(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .reset(reset),
        .load(load), .load_min(load_min), .load_sec(load_sec),
        .minutes(min_a), .seconds(sec_a), .status(st_a), .done(done_a));

    countdown_timer #(.CLKS_PER_SEC(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .reset(reset),
        .load(load), .load_min(load_min), .load_sec(load_sec),
        .minutes(min_b), .seconds(sec_b), .status(st_b), .done(done_b));

    typedef struct {
        logic       st, sp, rs, ld;
        logic [7:0] lm;
        logic [5:0] ls;
        logic [7:0] em;
        logic [5:0] es;
        logic [1:0] est;
        logic       ed;
    } vec_t;

    function automatic vec_t mk(input logic st, sp, rs, ld, input int lm, ls,
                                input int em, es, est, ed);
        vec_t v;
        v.st = st; v.sp = sp; v.rs = rs; v.ld = ld;
        v.lm = 8'(lm); v.ls = 6'(ls);
        v.em = 8'(em); v.es = 6'(es); v.est = 2'(est); v.ed = ed[0];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] m, input logic [5:0] s,
                       input logic [1:0] st, input logic d,
                       input int em, es, est, ed);
        total++;
        if (m !== 8'(em) || s !== 6'(es) || st !== 2'(est) || d !== ed[0]) begin
            bad++;
            $display("FAIL %s: got %0d:%0d st=%b done=%b, want %0d:%0d st=%0d done=%0d",
                     nm, m, s, st, d, em, es, est, ed);
        end
    endtask

    task automatic drive(input logic st, sp, rs, ld, input int lm, ls);
        start = st; stop = sp; reset = rs; load = ld;
        load_min = 8'(lm); load_sec = 6'(ls);
        @(posedge clk); #1;
    endtask

    vec_t tbl[21];

    initial begin
        // Table: CLKS_PER_SEC=1, every edge is a tick while RUNNING.
        //            st sp rs ld  lm  ls   em es est ed
        tbl[0]  = mk(0, 0, 0, 1,  1,  2,   1, 2, 0, 0);   // load 1:02
        tbl[1]  = mk(1, 0, 0, 0,  0,  0,   1, 2, 1, 0);   // start, no decrement yet
        tbl[2]  = mk(1, 0, 0, 0,  0,  0,   1, 1, 1, 0);
        tbl[3]  = mk(1, 0, 0, 0,  0,  0,   1, 0, 1, 0);
        tbl[4]  = mk(1, 0, 0, 0,  0,  0,   0, 59, 1, 0);  // minute borrow
        tbl[5]  = mk(1, 1, 0, 0,  0,  0,   0, 59, 2, 0);  // stop beats start
        tbl[6]  = mk(1, 0, 0, 0,  0,  0,   0, 59, 1, 0);  // resume
        tbl[7]  = mk(1, 0, 0, 0,  0,  0,   0, 58, 1, 0);
        tbl[8]  = mk(1, 0, 1, 1,  2,  0,   1, 2, 0, 0);   // reset beats load
        tbl[9]  = mk(0, 0, 0, 1,  0, 63,   0, 59, 0, 0);  // clamp
        tbl[10] = mk(0, 0, 0, 1,  0,  0,   0, 0, 0, 0);   // load 0:00
        tbl[11] = mk(1, 0, 0, 0,  0,  0,   0, 0, 0, 0);   // zero start ignored
        tbl[12] = mk(1, 0, 0, 0,  0,  0,   0, 0, 0, 0);
        tbl[13] = mk(0, 0, 0, 1,  0,  3,   0, 3, 0, 0);
        tbl[14] = mk(1, 0, 0, 0,  0,  0,   0, 3, 1, 0);
        tbl[15] = mk(1, 0, 0, 0,  0,  0,   0, 2, 1, 0);
        tbl[16] = mk(1, 0, 0, 0,  0,  0,   0, 1, 1, 0);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        tbl[17] = mk(1, 1, 0, 0,  0,  0,   0, 0, 1, 1);   // expiry beats stop
        tbl[18] = mk(1, 0, 0, 0,  0,  0,   0, 3, 1, 0);   // reload
        tbl[19] = mk(0, 1, 0, 0,  0,  0,   0, 3, 2, 0);
`else
        tbl[17] = mk(1, 1, 0, 0,  0,  0,   0, 0, 3, 1);   // expiry beats stop
        tbl[18] = mk(1, 0, 0, 0,  0,  0,   0, 0, 3, 0);   // done single pulse
        tbl[19] = mk(0, 1, 0, 0,  0,  0,   0, 0, 3, 0);   // stop ignored
`endif
        tbl[20] = mk(0, 0, 0, 1,  0,  2,   0, 2, 0, 0);   // load leaves EXPIRED

        // Reset state, no clock edge needed.
        #1;
        chk("reset_a", min_a, sec_a, st_a, done_a, 0, 0, 0, 0);
        chk("reset_b", min_b, sec_b, st_b, done_b, 0, 0, 0, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].st, tbl[i].sp, tbl[i].rs, tbl[i].ld, int'(tbl[i].lm), int'(tbl[i].ls));
            chk($sformatf("vec%0d", i), min_a, sec_a, st_a, done_a,
                int'(tbl[i].em), int'(tbl[i].es), int'(tbl[i].est), int'(tbl[i].ed));
        end

        // Full countdown from 1:02 with start held.
        drive(0, 0, 0, 1, 1, 2);
        drive(1, 0, 0, 0, 0, 0);
        chk("cd_start", min_a, sec_a, st_a, done_a, 1, 2, 1, 0);
        for (int i = 1; i <= 62; i++) begin
            int left;
            int est;
            left = 62 - i;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            est = 1;
`else
            est = (left == 0) ? 3 : 1;
`endif
            drive(1, 0, 0, 0, 0, 0);
            chk($sformatf("cd%0d", i), min_a, sec_a, st_a, done_a,
                left / 60, left % 60, est, (left == 0) ? 1 : 0);
        end
        drive(1, 0, 0, 0, 0, 0);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        chk("cd_after", min_a, sec_a, st_a, done_a, 1, 2, 1, 0);
`else
        chk("cd_after", min_a, sec_a, st_a, done_a, 0, 0, 3, 0);
`endif

        // Pause/resume on the CLKS_PER_SEC=4 instance.
        drive(0, 0, 0, 1, 0, 10);
        chk("p_load", min_b, sec_b, st_b, done_b, 0, 10, 0, 0);
        drive(1, 0, 0, 0, 0, 0);                 // start edge, prescaler 0
        chk("p_start", min_b, sec_b, st_b, done_b, 0, 10, 1, 0);
        for (int i = 1; i <= 6; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            chk($sformatf("p_run%0d", i), min_b, sec_b, st_b, done_b,
                0, (i >= 4) ? 9 : 10, 1, 0);
        end
        drive(0, 1, 0, 0, 0, 0);                 // prescaler held at 2
        chk("p_stop", min_b, sec_b, st_b, done_b, 0, 9, 2, 0);
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            chk($sformatf("p_hold%0d", i), min_b, sec_b, st_b, done_b, 0, 9, 2, 0);
        end
        drive(1, 0, 0, 0, 0, 0);
        chk("p_resume", min_b, sec_b, st_b, done_b, 0, 9, 1, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("p_res1", min_b, sec_b, st_b, done_b, 0, 9, 1, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("p_res2", min_b, sec_b, st_b, done_b, 0, 8, 1, 0);

        // Priority: running at 0:05 with preset 0:30.
        drive(0, 0, 0, 1, 0, 30);
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 25; i++) drive(1, 0, 0, 0, 0, 0);
        chk("pri_pre", min_a, sec_a, st_a, done_a, 0, 5, 1, 0);
        drive(1, 0, 1, 1, 2, 0);
        chk("pri", min_a, sec_a, st_a, done_a, 0, 30, 0, 0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        drive(0, 0, 0, 1, 0, 2);
        drive(1, 0, 0, 0, 0, 0);
        chk("ar_start", min_a, sec_a, st_a, done_a, 0, 2, 1, 0);
        for (int i = 0; i < 9; i++) begin
            int v;
            v = (i % 3 == 0) ? 1 : (i % 3 == 1) ? 0 : 2;
            drive(1, 0, 0, 0, 0, 0);
            chk($sformatf("ar%0d", i), min_a, sec_a, st_a, done_a,
                0, v, 1, (v == 0) ? 1 : 0);
        end
`endif

        // Asynchronous reset mid-run.
        drive(0, 0, 0, 1, 1, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        chk("ar_pre", min_a, sec_a, st_a, done_a, 0, 58, 1, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("async_a", min_a, sec_a, st_a, done_a, 0, 0, 0, 0);
        chk("async_b", min_b, sec_b, st_b, done_b, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 0, 0);                 // preset now 0:00, cannot start
        chk("post_rst", min_a, sec_a, st_a, done_a, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
